// File: rtl/smi_self_flow_fork_buffer.sv
// smi_self_flow_fork_buffer: SELF-handshake fork with one register slot per branch,
// optional per-payload branch mask and a saturating count of empty-mask drops.
module smi_self_flow_fork_buffer #(
  parameter int NumPorts   = 2,
  parameter int DataWidth  = 32,
  parameter int MaskEnable = 1
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          dataInReady,
  output logic                          dataInStop,
  input  logic [DataWidth-1:0]          dataIn,
  input  logic [NumPorts-1:0]           dataInMask,
  output logic [NumPorts-1:0]           dataOutReady,
  input  logic [NumPorts-1:0]           dataOutStop,
  output logic [NumPorts*DataWidth-1:0] dataOut,
  output logic [15:0]                   dropCount,
  output logic                          idle
);
  logic [NumPorts-1:0]  maskEff;
  logic [NumPorts-1:0]  bufValid;
  logic [DataWidth-1:0] bufData [NumPorts];
  logic                 accept;
  assign maskEff    = (MaskEnable != 0) ? dataInMask : '1;
  // Only a selected branch that is both full and stalled can block the input.
  assign dataInStop = |(maskEff & bufValid & dataOutStop);
  assign accept     = dataInReady & ~dataInStop;
  assign dataOutReady = bufValid;
  assign idle         = ~|bufValid;
  for (genvar g = 0; g < NumPorts; g++) begin : gOut
    assign dataOut[g*DataWidth +: DataWidth] = bufData[g];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (accept && maskEff[i]) begin
        bufValid[i] <= 1'b1;
        bufData[i]  <= dataIn;
      end else if (!dataOutStop[i]) begin
        bufValid[i] <= 1'b0;
      end
    end
    if (accept && maskEff == '0 && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    if (srst) begin
      bufValid  <= '0;
      dropCount <= '0;
    end
  end
endmodule

// File: doc/smi_self_flow_fork_buffer.md
SMI_SELF_FLOW_FORK_BUFFER -- requirements
Module: smi_self_flow_fork_buffer

Interface
REQ-001 The block SHALL have parameter NumPorts, default 2: number of fork output branches, legal range 1..16.
REQ-002 The block SHALL have parameter DataWidth, default 32: payload width in bits, minimum 1.
REQ-003 The block SHALL have parameter MaskEnable, default 1: 1 = selective fork using dataInMask; 0 = broadcast, dataInMask ignored and treated as all ones.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port srst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port dataInReady, input, 1 bit: upstream asserts that dataIn/dataInMask are valid.
REQ-007 The block SHALL have port dataInStop, output, 1 bit: upstream transfer stalled.
REQ-008 The block SHALL have port dataIn, input, DataWidth bits: payload.
REQ-009 The block SHALL have port dataInMask, input, NumPorts bits: branch-select mask for this payload.
REQ-010 The block SHALL have port dataOutReady, output, NumPorts bits: per-branch valid.
REQ-011 The block SHALL have port dataOutStop, input, NumPorts bits: per-branch downstream stall.
REQ-012 The block SHALL have port dataOut, output, NumPorts*DataWidth bits: branch i payload in bits [i*DataWidth +: DataWidth].
REQ-013 The block SHALL have port dropCount, output, 16 bits: count of payloads consumed with an empty effective mask.
REQ-014 The block SHALL have port idle, output, 1 bit: high when all branch buffers are empty.

Function
REQ-015 Handshake on every side SHALL be SELF: a transfer occurs in a cycle where Ready=1 and Stop=0; the sender holds Ready, data and mask stable until the transfer.
REQ-016 The effective mask maskEff SHALL equal dataInMask when MaskEnable=1 and all ones when MaskEnable=0.
REQ-017 Each branch i SHALL own a single-entry register: bufValid[i] plus bufData[i] (DataWidth bits).
REQ-018 dataInStop SHALL equal the OR over i of (maskEff[i] & bufValid[i] & dataOutStop[i]), computed combinationally with no register on the path.
REQ-019 An input accept SHALL be defined as dataInReady & ~dataInStop.
REQ-020 On accept, every branch with maskEff[i]=1 SHALL load bufData[i]<=dataIn and set bufValid[i]; branches with maskEff[i]=0 SHALL be left unchanged.
REQ-021 Without a load, bufValid[i] SHALL clear when bufValid[i] & ~dataOutStop[i], and hold otherwise.
REQ-022 A branch completing an output transfer and being reloaded in the same cycle SHALL end with bufValid[i]=1 and the new data, giving full throughput of 1 payload/cycle per branch.
REQ-023 dataOutReady[i] SHALL equal bufValid[i], and dataOut slice i SHALL equal bufData[i], both registered outputs.
REQ-024 Latency from input accept to dataOutReady[i] high SHALL be exactly 1 cycle.
REQ-025 The block SHALL never drop, duplicate or reorder a payload on any branch whose mask bit was set; an unselected branch never sees the payload.
REQ-026 A stalled branch whose mask bit is 0 for the current payload SHALL NOT stall the input.
REQ-027 An accept with maskEff == 0 SHALL consume the payload, change no buffer, and increment dropCount.
REQ-028 dropCount SHALL be 16-bit, saturating at 16'hFFFF.
REQ-029 idle SHALL equal ~|bufValid.
REQ-030 With NumPorts=1 and MaskEnable=0, the block SHALL behave as a single-entry SELF pipeline register.

Reset
REQ-031 While srst=1 at a clock edge, the block SHALL clear bufValid to all zeros, set dropCount to 0 and set idle to 1; bufData need not be reset.
REQ-032 During reset, dataOutReady SHALL be 0 one cycle after the first srst edge, and dataInStop SHALL be 0 because all buffers are empty.
REQ-033 Reset asserted mid-operation SHALL discard all buffered payloads, regardless of any dataOutStop state.

Verification
REQ-034 Broadcast with NumPorts=2, MaskEnable=1, mask=2'b11, dataOutStop=0: drive dataIn=0xA5 for one cycle -> both dataOutReady high next cycle with slice=0xA5 for exactly 1 cycle; dataInStop stays 0.
REQ-035 Selective with a stalled unused branch: dataOutStop=2'b10 and branch 1 holding 0x11; present 0x22 with mask=2'b01 -> accepted with dataInStop=0, branch 0 outputs 0x22, branch 1 still holds 0x11.
REQ-036 Backpressure: branch 0 holds 0x33 with dataOutStop[0]=1; present 0x44 with mask=2'b11 -> dataInStop=1 until dataOutStop[0] falls; the next cycle both branches show 0x44, and branch 1 receives 0x44 only once.
REQ-037 Streaming: 8 back-to-back payloads 0..7, mask=2'b11, no stalls -> each branch outputs 0..7 on consecutive cycles, 1-cycle latency, dataInStop never high.
REQ-038 Drop counter: 3 accepts with mask=0 -> dropCount=3 and no dataOutReady pulse; with dropCount preloaded to 0xFFFF via 65535 drops, one more drop -> dropCount stays 0xFFFF.
REQ-039 Reset mid-stall: both buffers full and stalled, assert srst for one cycle -> next cycle dataOutReady=0, idle=1, dropCount=0, dataInStop=0.
